// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, ALU opcode encodings and scoreboard layout for the issue/hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 2;
  localparam int DEPTH_DEF  = 3;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  // One scoreboard slot at default width: {valid, destination}.
  typedef struct packed {
    logic                  vld;
    logic [ADDR_W_DEF-1:0] addr;
  } pend_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// One source register against every scoreboard slot; combinational, no backpressure.
// match_any = hits that must stall (excludes a forwardable oldest hit when FWD_EN), match_oldest = forwardable hit.
module hazard_cmp #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b0
) (
  input  logic [ADDR_W-1:0]            i_src,
  input  logic [DEPTH-1:0]             i_vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
  output logic                         o_match_any,
  output logic                         o_match_oldest
);

  logic [DEPTH-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit[k] = i_vld[k] && (i_addr[k] == i_src);
    end
  end

  // With forwarding the oldest slot's result is on the bypass, so only younger hits stall.
  assign o_match_any    = FWD_EN ? (|w_hit[DEPTH-2:0]) : (|w_hit);
  assign o_match_oldest = FWD_EN && w_hit[DEPTH-1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/RAW-hazard controller: accept -> issue next cycle, 1/cycle; stalls fetch (ins_ready=0) on hazard or hold.
// Build option HAZARD_FWD_EN: oldest in-flight match forwards instead of stalling.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [OP_W-1:0]   ins_op,
  input  logic [ADDR_W-1:0] ins_write_addr,
  input  logic [ADDR_W-1:0] ins_read_addr1,
  input  logic [ADDR_W-1:0] ins_read_addr2,
  input  logic              hold,
  output logic              issue_valid,
  output logic [OP_W-1:0]   issue_op,
  output logic [ADDR_W-1:0] issue_wr_addr,
  output logic [ADDR_W-1:0] issue_rd_addr1,
  output logic [ADDR_W-1:0] issue_rd_addr2,
  output logic              fwd_sel1,
  output logic              fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  issue_cnt
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]             r_pend_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] r_pend_addr;
  logic [OP_W-1:0]              r_op;
  logic [ADDR_W-1:0]            r_rd1;
  logic [ADDR_W-1:0]            r_rd2;
  logic                         r_fwd1;
  logic                         r_fwd2;
  logic [CNT_W-1:0]             r_stall_cnt;
  logic [CNT_W-1:0]             r_issue_cnt;

  logic              w_any1;
  logic              w_any2;
  logic              w_old1;
  logic              w_old2;
  logic              w_hazard;
  logic              w_accept;
  logic [ADDR_W-1:0] w_new_addr;

  hazard_cmp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_cmp_rd1 (
    .i_src          (ins_read_addr1),
    .i_vld          (r_pend_vld),
    .i_addr         (r_pend_addr),
    .o_match_any    (w_any1),
    .o_match_oldest (w_old1)
  );

  hazard_cmp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_cmp_rd2 (
    .i_src          (ins_read_addr2),
    .i_vld          (r_pend_vld),
    .i_addr         (r_pend_addr),
    .o_match_any    (w_any2),
    .o_match_oldest (w_old2)
  );

  assign w_hazard   = ins_valid && (w_any1 || w_any2);
  assign ins_ready  = !hold && !w_hazard;
  assign w_accept   = ins_valid && ins_ready;
  assign w_new_addr = w_accept ? ins_write_addr : {ADDR_W{1'b0}};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pend_vld  <= '0;
      r_pend_addr <= '0;
      r_op        <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_fwd1      <= 1'b0;
      r_fwd2      <= 1'b0;
      r_stall_cnt <= '0;
      r_issue_cnt <= '0;
    end else if (!hold) begin
      // Slot 0 is the issue register; a stall drops a bubble into it.
      r_pend_vld  <= {r_pend_vld[DEPTH-2:0], w_accept};
      r_pend_addr <= {r_pend_addr[DEPTH-2:0], w_new_addr};
      r_op        <= w_accept ? ins_op : {OP_W{1'b0}};
      r_rd1       <= w_accept ? ins_read_addr1 : {ADDR_W{1'b0}};
      r_rd2       <= w_accept ? ins_read_addr2 : {ADDR_W{1'b0}};
      r_fwd1      <= w_accept && w_old1;
      r_fwd2      <= w_accept && w_old2;
      if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_accept && (r_issue_cnt != {CNT_W{1'b1}})) begin
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
    end
  end

  assign issue_valid    = r_pend_vld[0];
  assign issue_op       = r_op;
  assign issue_wr_addr  = r_pend_addr[0];
  assign issue_rd_addr1 = r_rd1;
  assign issue_rd_addr2 = r_rd2;
  assign fwd_sel1       = r_fwd1;
  assign fwd_sel2       = r_fwd2;
  assign stall_cnt      = r_stall_cnt;
  assign issue_cnt      = r_issue_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic against a
// timestamp-based in-flight model; small counter width so saturation is reachable.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int AW    = 5;
  localparam int OW    = 2;
  localparam int DEPTH = 3;
  localparam int CW    = 8;
  localparam int SAT   = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [OW-1:0] ins_op = '0;
  logic [AW-1:0] ins_write_addr = '0;
  logic [AW-1:0] ins_read_addr1 = '0;
  logic [AW-1:0] ins_read_addr2 = '0;
  logic          hold = 1'b0;
  logic          issue_valid;
  logic [OW-1:0] issue_op;
  logic [AW-1:0] issue_wr_addr;
  logic [AW-1:0] issue_rd_addr1;
  logic [AW-1:0] issue_rd_addr2;
  logic          fwd_sel1;
  logic          fwd_sel2;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] issue_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(AW), .OP_W(OW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_op         (ins_op),
    .ins_write_addr (ins_write_addr),
    .ins_read_addr1 (ins_read_addr1),
    .ins_read_addr2 (ins_read_addr2),
    .hold           (hold),
    .issue_valid    (issue_valid),
    .issue_op       (issue_op),
    .issue_wr_addr  (issue_wr_addr),
    .issue_rd_addr1 (issue_rd_addr1),
    .issue_rd_addr2 (issue_rd_addr2),
    .fwd_sel1       (fwd_sel1),
    .fwd_sel2       (fwd_sel2),
    .stall_cnt      (stall_cnt),
    .issue_cnt      (issue_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: every accepted instruction remembers the tick (count of non-hold edges) at
  // which it entered issue; its age now-tick places it in the pipeline until age DEPTH.
  typedef struct {
    int            tick;
    logic [AW-1:0] wr;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [OW-1:0] op;
    logic          f1;
    logic          f2;
  } flight_t;

  flight_t inflight[$];
  int      now     = 0;
  int      m_stall = 0;
  int      m_issue = 0;

  task automatic step(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] w,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic h,
                      output logic acc);
    logic          young1, young2, old1, old2, haz, rdy, iv, if1, if2;
    logic [AW-1:0] iw, ir1, ir2;
    logic [OW-1:0] iop;
    int            age;
    ins_valid = v; ins_op = op; ins_write_addr = w;
    ins_read_addr1 = r1; ins_read_addr2 = r2; hold = h;
    young1 = 0; young2 = 0; old1 = 0; old2 = 0;
    iv = 0; iw = '0; ir1 = '0; ir2 = '0; iop = '0; if1 = 0; if2 = 0;
    foreach (inflight[i]) begin
      age = now - inflight[i].tick;
      if (age == 0) begin
        iv = 1; iw = inflight[i].wr; ir1 = inflight[i].r1; ir2 = inflight[i].r2;
        iop = inflight[i].op; if1 = inflight[i].f1; if2 = inflight[i].f2;
      end
      if (inflight[i].wr == r1) begin
        if (FWD == 1 && age == DEPTH - 1) old1 = 1; else young1 = 1;
      end
      if (inflight[i].wr == r2) begin
        if (FWD == 1 && age == DEPTH - 1) old2 = 1; else young2 = 1;
      end
    end
    haz = v && (young1 || young2);
    rdy = !h && !haz;
    acc = v && rdy;
    @(negedge clk);
    check_eq("ins_ready", {31'd0, ins_ready}, {31'd0, rdy});
    check_eq("issue_valid", {31'd0, issue_valid}, {31'd0, iv});
    check_eq("issue_op", 32'(issue_op), 32'(iop));
    check_eq("issue_wr_addr", 32'(issue_wr_addr), 32'(iw));
    check_eq("issue_rd_addr1", 32'(issue_rd_addr1), 32'(ir1));
    check_eq("issue_rd_addr2", 32'(issue_rd_addr2), 32'(ir2));
    check_eq("fwd_sel1", {31'd0, fwd_sel1}, {31'd0, if1});
    check_eq("fwd_sel2", {31'd0, fwd_sel2}, {31'd0, if2});
    check_eq("stall_cnt", 32'(stall_cnt), m_stall);
    check_eq("issue_cnt", 32'(issue_cnt), m_issue);
    @(posedge clk);
    if (!h) begin
      if (haz && m_stall < SAT) m_stall++;
      if (acc) begin
        if (m_issue < SAT) m_issue++;
        inflight.push_back('{now + 1, w, r1, r2, op, old1, old2});
      end
      now++;
      while (inflight.size() > 0 && now - inflight[0].tick >= DEPTH) void'(inflight.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    ins_valid = 1'b1; hold = 1'b0;
    ins_read_addr1 = 5'd1; ins_read_addr2 = 5'd2; ins_write_addr = 5'd3;
    rstN = 1'b0;
    #2;
    check_eq("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check_eq("rst_ins_ready", {31'd0, ins_ready}, 32'd1);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check_eq("rst_fwd", {30'd0, fwd_sel1, fwd_sel2}, 32'd0);
    inflight.delete();
    m_stall = 0;
    m_issue = 0;
    ins_valid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b0, a);
  endtask

  // Present one instruction until accepted or the budget expires; returns stalled cycles.
  task automatic issue_until(input logic [AW-1:0] w, input logic [AW-1:0] r1,
                             input logic [AW-1:0] r2, input string tag, output int stalls);
    logic a;
    stalls = 0;
    a = 1'b0;
    for (int i = 0; i < 16 && !a; i++) begin
      step(1'b1, OP_ADD, w, r1, r2, 1'b0, a);
      if (!a) stalls++;
    end
    check_eq(tag, {31'd0, a}, 32'd1);
  endtask

  initial begin
    logic a;
    int   n;
    int   budget;

    do_reset();

    // Independent stream
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, OP_SUB, AW'(i), AW'(16 + i), AW'(24 + i), 1'b0, a);
      check_eq("indep_accept", {31'd0, a}, 32'd1);
    end
    idle(DEPTH);
    check_eq("indep_issue_cnt", 32'(issue_cnt), 32'd4);
    check_eq("indep_stall_cnt", 32'(stall_cnt), 32'd0);

    // Write r3 then read r3 on source 1
    do_reset();
    step(1'b1, OP_AND, 5'd3, 5'd20, 5'd21, 1'b0, a);
    check_eq("dep_first_accept", {31'd0, a}, 32'd1);
    issue_until(5'd12, 5'd3, 5'd9, "dep_accept", n);
    check_eq("dep_stalls", n, DEPTH - FWD);
    check_eq("dep_issue_valid", {31'd0, issue_valid}, 32'd1);
    check_eq("dep_fwd_sel1", {31'd0, fwd_sel1}, FWD);
    check_eq("dep_fwd_sel2", {31'd0, fwd_sel2}, 32'd0);
    check_eq("dep_stall_cnt", 32'(stall_cnt), DEPTH - FWD);
    idle(DEPTH);

    // Both sources on r5: one count per stalled cycle
    do_reset();
    step(1'b1, OP_OR, 5'd5, 5'd0, 5'd1, 1'b0, a);
    issue_until(5'd6, 5'd5, 5'd5, "both_accept", n);
    check_eq("both_stall_cnt", 32'(stall_cnt), DEPTH - FWD);
    check_eq("both_fwd", {30'd0, fwd_sel1, fwd_sel2}, (FWD == 1) ? 32'd3 : 32'd0);
    idle(DEPTH);

    // Hold during a stall freezes everything
    do_reset();
    step(1'b1, OP_ADD, 5'd7, 5'd0, 5'd1, 1'b0, a);
    step(1'b1, OP_ADD, 5'd8, 5'd7, 5'd2, 1'b0, a);
    check_eq("hold_pre_stall", {31'd0, a}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, OP_ADD, 5'd8, 5'd7, 5'd2, 1'b1, a);
      check_eq("hold_stall_cnt", 32'(stall_cnt), 32'd1);
      check_eq("hold_issue_valid", {31'd0, issue_valid}, 32'd0);
    end
    issue_until(5'd8, 5'd7, 5'd2, "hold_accept", n);
    check_eq("hold_total_stall", 32'(stall_cnt), DEPTH - FWD);
    idle(DEPTH);

    // Saturation: dependent r5 chain until stall_cnt must pin at all-ones
    do_reset();
    budget = 0;
    while (m_stall < SAT + 4 && budget < 400) begin
      issue_until(5'd5, 5'd5, 5'd5, "sat_accept", n);
      budget++;
    end
    check_eq("sat_stall_cnt", 32'(stall_cnt), SAT);
    idle(DEPTH);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom_range(0, 9) < 7), OW'($urandom_range(0, 3)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), a);
    end
    check_eq("rand_issue_sat", 32'(issue_cnt), m_issue);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
